token_bucket_mc: RTL and testbench
==================================

// Module: token_bucket_mc
// PURPOSE
//  Multi-channel successor to the single-channel token-bucket shaper. Keeps one bucket
//  per channel, each with a runtime-programmable refill rate. A round-robin arbiter
//  picks at most one conforming channel per cycle toward a shared, back-pressurable
//  downstream port. Sits between NCH request sources and one shared egress.
// PARAMETERS
//  NCH          4    number of channels (>=2)
//  DEN          16   token scale: tokens per request unit
//  BURST_MAX    8    max buffered requests per channel; TOK_MAX = BURST_MAX*DEN
//  TOKEN_COST   16   tokens consumed per grant (<= TOK_MAX)
//  RATE_W       8    width of the per-channel rate field
//  RATE_DEFAULT 3    per-channel rate after reset (tokens/cycle)
//  (local) TOK_W = clog2(TOK_MAX + 2**RATE_W); CH_W = clog2(NCH)
// PORTS
//  clk          in   1           clock, all logic on rising edge
//  rst          in   1           synchronous reset, active-high
//  req_i        in   NCH         per-channel request (level)
//  out_ready_i  in   1           downstream can accept a grant this cycle
//  grant_o      out  NCH         one-hot grant (all-zero if none)
//  grant_vld_o  out  1           |grant_o
//  grant_id_o   out  CH_W        index of granted channel (0 when none)
//  ready_o      out  NCH         channel would conform this cycle (tokens_acc >= COST)
//  cfg_we_i     in   1           config write strobe
//  cfg_ch_i     in   CH_W        target channel of config write
//  cfg_rate_i   in   RATE_W      new refill rate for cfg_ch_i
//  cfg_clr_i    in   1           with cfg_we_i: empty the target bucket
// BEHAVIOUR
//  - Reset: tok[c]=TOK_MAX, rate[c]=RATE_DEFAULT, rr_ptr=0 for all c. Outputs are
//    combinational from state, so during/after reset grant_o=0 unless req_i is high.
//  - Per cycle, per channel: acc[c] = min(tok[c]+rate[c], TOK_MAX), computed in TOK_W
//    bits (no overflow). ready_o[c] = (acc[c] >= TOKEN_COST).
//  - Eligible: elig[c] = req_i[c] & ready_o[c] & out_ready_i.
//  - Arbitration: first eligible channel scanning rr_ptr, rr_ptr+1, ... mod NCH.
//    Grant is same-cycle (0 latency), one channel max.
//  - Update at posedge: tok[c] <= acc[c] - (granted c ? TOKEN_COST : 0).
//    On grant to k: rr_ptr <= (k+1) mod NCH; no grant: rr_ptr holds.
//  - out_ready_i=0: no grants; buckets still accrue and saturate; rr_ptr holds.
//  - Config write: rate[cfg_ch_i] <= cfg_rate_i, effective from next cycle. The
//    current-cycle accrual and grant use the old rate. If cfg_clr_i: tok[cfg_ch_i] <= 0,
//    overriding accrual and deduction; a grant already issued that cycle stands.
//  - rate=0: channel drains, then never conforms again until rate is raised.
//  - rate >= TOKEN_COST: a lone requesting channel is granted every cycle.
//  - Out-of-range cfg_ch_i (>= NCH) is ignored.
//  - Reset mid-operation restores the reset state on the next edge. In-flight
//    grants that cycle are not deducted.
//  - No grant without request. grant_o is always one-hot or zero.
// TESTING (NCH=4, DEN=16, COST=16, BURST_MAX=8, rate=3 unless stated)
//  1 Only ch0 req for 40 cycles from reset -> 9 back-to-back grants (tok
//    112,99,..,8), then grants at cycles 12,17,23,28,33,39; total 15.
//  2 All 4 req held, out_ready=1 -> grant_id 0,1,2,3,0,... strictly rotating.
//    No channel is granted twice before the others while all are conforming.
//  3 All req, out_ready=0 for 20 cycles -> zero grants, all tok=128, rr_ptr unchanged.
//    Raising out_ready -> first grant goes to the rr_ptr channel.
//  4 cfg ch1 rate=0, then ch1 req only -> exactly 8 grants, then none forever.
//    cfg rate=16 -> grant every cycle. Rate write in the grant cycle uses the old rate.
//  5 cfg_clr on ch2 while ch2 is granted -> grant stands, tok[2]=0 next cycle.
//    ready_o[2] stays low until acc >= 16 (6 cycles at rate 3).
//  6 Scoreboard: random req (30%/ch) plus random cfg writes, 2000 cycles.
//    Per-channel reference model matches grant_o every cycle; 0 mismatches.

Source files
------------

// File: rtl/token_bucket_mc_if.sv
// Request/grant and configuration bundle between NCH request sources and the
// multi-channel token-bucket shaper.
interface token_bucket_mc_if #(
  parameter int NCH    = 4,
  parameter int RATE_W = 8
) ();
  localparam int CH_W = $clog2(NCH);

  logic [NCH-1:0]    req_i;
  logic              out_ready_i;
  logic [NCH-1:0]    grant_o;
  logic              grant_vld_o;
  logic [CH_W-1:0]   grant_id_o;
  logic [NCH-1:0]    ready_o;
  logic              cfg_we_i;
  logic [CH_W-1:0]   cfg_ch_i;
  logic [RATE_W-1:0] cfg_rate_i;
  logic              cfg_clr_i;

  modport master (
    output req_i, out_ready_i, cfg_we_i, cfg_ch_i, cfg_rate_i, cfg_clr_i,
    input  grant_o, grant_vld_o, grant_id_o, ready_o
  );

  modport slave (
    input  req_i, out_ready_i, cfg_we_i, cfg_ch_i, cfg_rate_i, cfg_clr_i,
    output grant_o, grant_vld_o, grant_id_o, ready_o
  );
endinterface

// File: rtl/token_bucket_mc.sv
// Per-channel token buckets with programmable refill rate, feeding one shared
// back-pressurable egress through a same-cycle round-robin arbiter.
module token_bucket_mc #(
  parameter int NCH          = 4,
  parameter int DEN          = 16,
  parameter int BURST_MAX    = 8,
  parameter int TOKEN_COST   = 16,
  parameter int RATE_W       = 8,
  parameter int RATE_DEFAULT = 3
) (
  input logic               clk,
  input logic               rst,
  token_bucket_mc_if.slave  bus
);
  localparam int TOK_MAX = BURST_MAX * DEN;
  localparam int TOK_W   = $clog2(TOK_MAX + 2**RATE_W);
  localparam int CH_W    = $clog2(NCH);
  localparam logic [TOK_W-1:0] TOK_MAX_V = TOK_W'(TOK_MAX);
  localparam logic [TOK_W-1:0] COST_V    = TOK_W'(TOKEN_COST);

  logic [TOK_W-1:0]  tok_q  [NCH];
  logic [TOK_W-1:0]  tok_d  [NCH];
  logic [TOK_W-1:0]  acc    [NCH];
  logic [RATE_W-1:0] rate_q [NCH];
  logic [RATE_W-1:0] rate_d [NCH];
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NCH-1:0]    ready, elig, grant;
  logic [CH_W-1:0]   gid;
  logic              found;
  logic              cfg_hit;

  // TOK_W leaves headroom for TOK_MAX + max rate, so the sum cannot wrap.
  function automatic logic [TOK_W-1:0] sat_accrue(input logic [TOK_W-1:0]  tok,
                                                   input logic [RATE_W-1:0] rate);
    logic [TOK_W-1:0] sum;
    sum = tok + TOK_W'(rate);
    return (sum > TOK_MAX_V) ? TOK_MAX_V : sum;
  endfunction

  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
    logic [CH_W:0] s;
    s = {1'b0, base} + (CH_W+1)'(off);
    if (s >= (CH_W+1)'(NCH)) s = s - (CH_W+1)'(NCH);
    return s[CH_W-1:0];
  endfunction

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      acc[c]   = sat_accrue(tok_q[c], rate_q[c]);
      ready[c] = (acc[c] >= COST_V);
    end
    elig = ready & bus.req_i & {NCH{bus.out_ready_i}};
  end

  // Scan starts at rr_ptr so the channel after the last winner has priority.
  always_comb begin
    found = 1'b0;
    gid   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && elig[rr_idx(rr_ptr_q, i)]) begin
        found = 1'b1;
        gid   = rr_idx(rr_ptr_q, i);
      end
    end
    grant = found ? (NCH'(1) << gid) : '0;
  end

  assign cfg_hit = bus.cfg_we_i && ({1'b0, bus.cfg_ch_i} < (CH_W+1)'(NCH));

  // A clear overrides accrual and deduction, but the grant already issued stands.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      tok_d[c]  = acc[c] - (grant[c] ? COST_V : '0);
      rate_d[c] = rate_q[c];
      if (cfg_hit && bus.cfg_ch_i == CH_W'(c)) begin
        rate_d[c] = bus.cfg_rate_i;
        if (bus.cfg_clr_i) tok_d[c] = '0;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (found) rr_ptr_d = (gid == CH_W'(NCH - 1)) ? '0 : gid + CH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        tok_q[c]  <= TOK_MAX_V;
        rate_q[c] <= RATE_W'(RATE_DEFAULT);
      end
      rr_ptr_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        tok_q[c]  <= tok_d[c];
        rate_q[c] <= rate_d[c];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.grant_o     = grant;
  assign bus.grant_vld_o = found;
  assign bus.grant_id_o  = gid;
  assign bus.ready_o     = ready;
endmodule

// File: tb/tb_token_bucket_mc.sv
// Bench for token_bucket_mc: directed scenarios plus a per-cycle reference model
// whose predictions are queued and compared against the DUT outputs.
module tb_token_bucket_mc;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  token_bucket_mc_if #(.NCH(NCH), .RATE_W(8)) bus ();

  token_bucket_mc #(
    .NCH(NCH), .DEN(16), .BURST_MAX(8), .TOKEN_COST(16), .RATE_W(8), .RATE_DEFAULT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] grant;
    logic       vld;
    logic [1:0] id;
    logic [3:0] ready;
    int         g;
  } exp_t;

  exp_t sb_q[$];
  int   m_tok[NCH], m_rate[NCH], m_acc[NCH], m_rr;
  int   n_chk = 0, n_pass = 0;
  logic       obs_vld;
  logic [1:0] obs_id;
  logic [3:0] obs_ready;
  int         cnt;
  logic [63:0] mask;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_tok[c]  = 128;
      m_rate[c] = 3;
    end
    m_rr = 0;
  endtask

  task automatic model_eval(output exp_t e);
    int a, ch;
    e.grant = '0; e.vld = 1'b0; e.id = '0; e.ready = '0; e.g = -1;
    for (int c = 0; c < NCH; c++) begin
      a = m_tok[c] + m_rate[c];
      if (a > 128) a = 128;
      m_acc[c]   = a;
      e.ready[c] = (a >= 16);
    end
    if (bus.out_ready_i) begin
      for (int k = 0; k < NCH; k++) begin
        ch = (m_rr + k) % NCH;
        if (e.g < 0 && bus.req_i[ch] && e.ready[ch]) e.g = ch;
      end
    end
    if (e.g >= 0) begin
      e.vld = 1'b1;
      e.id = e.g[1:0];
      e.grant[e.g] = 1'b1;
    end
  endtask

  task automatic model_update(input exp_t e);
    int ch;
    if (rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < NCH; c++) m_tok[c] = m_acc[c] - ((e.g == c) ? 16 : 0);
      if (e.g >= 0) m_rr = (e.g + 1) % NCH;
      if (bus.cfg_we_i) begin
        ch = int'(bus.cfg_ch_i);
        m_rate[ch] = int'(bus.cfg_rate_i);
        if (bus.cfg_clr_i) m_tok[ch] = 0;
      end
    end
  endtask

  task automatic step();
    exp_t e, r;
    model_eval(e);
    sb_q.push_back(e);
    @(negedge clk);
    r = sb_q.pop_front();
    obs_vld   = bus.grant_vld_o;
    obs_id    = bus.grant_id_o;
    obs_ready = bus.ready_o;
    chk("grant", {bus.grant_vld_o, bus.grant_id_o, bus.grant_o}, {r.vld, r.id, r.grant});
    chk("ready", bus.ready_o, r.ready);
    model_update(r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_i = '0; bus.out_ready_i = 1'b1;
    bus.cfg_we_i = 1'b0; bus.cfg_ch_i = '0; bus.cfg_rate_i = '0; bus.cfg_clr_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // lone channel 0 draining from a full bucket
    bus.req_i = 4'b0001;
    cnt = 0; mask = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (obs_vld) begin
        cnt++;
        mask |= 64'(1) << i;
      end
    end
    chk("t1_total", cnt, 15);
    chk("t1_cycles", mask, 64'h41_0841_09FF);

    // strict rotation with all channels requesting
    do_reset();
    bus.req_i = 4'hF;
    for (int i = 0; i < 14; i++) begin
      step();
      chk("t2_rot", {obs_vld, obs_id}, {1'b1, 2'(i % 4)});
    end

    // back-pressure: no grants, buckets refill, pointer held at 2
    bus.out_ready_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_vld) cnt++;
    end
    chk("t3_nogrant", cnt, 0);
    chk("t3_full", obs_ready, 4'hF);
    bus.out_ready_i = 1'b1;
    step();
    chk("t3_first", {obs_vld, obs_id}, {1'b1, 2'd2});

    // rate 0 drains exactly the burst, rate 16 grants every cycle
    do_reset();
    bus.cfg_we_i = 1'b1; bus.cfg_ch_i = 2'd1; bus.cfg_rate_i = 8'd0;
    step();
    bus.cfg_we_i = 1'b0; bus.req_i = 4'b0010;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (obs_vld) cnt++;
    end
    chk("t4_drain", cnt, 8);
    bus.cfg_we_i = 1'b1; bus.cfg_rate_i = 8'd16;
    step();
    chk("t4_cfgcycle", obs_vld, 1'b0);
    bus.cfg_we_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_vld) cnt++;
    end
    chk("t4_fast", cnt, 10);
    bus.cfg_we_i = 1'b1; bus.cfg_rate_i = 8'd0;
    step();
    chk("t4_oldrate", obs_vld, 1'b1);
    bus.cfg_we_i = 1'b0;
    step();
    chk("t4_drained", obs_vld, 1'b0);

    // clear during a grant: grant stands, bucket restarts from zero
    do_reset();
    bus.req_i = 4'b0100;
    bus.cfg_we_i = 1'b1; bus.cfg_ch_i = 2'd2; bus.cfg_rate_i = 8'd3; bus.cfg_clr_i = 1'b1;
    step();
    chk("t5_grant", {obs_vld, obs_id}, {1'b1, 2'd2});
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_ready", obs_ready[2], (i == 5));
    end

    // random traffic, config writes and occasional mid-run reset
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < NCH; c++) bus.req_i[c] = ($urandom_range(0, 99) < 30);
      bus.out_ready_i = ($urandom_range(0, 99) < 85);
      bus.cfg_we_i    = ($urandom_range(0, 99) < 8);
      bus.cfg_ch_i    = 2'($urandom_range(0, NCH - 1));
      bus.cfg_rate_i  = 8'($urandom_range(0, 20));
      bus.cfg_clr_i   = ($urandom_range(0, 99) < 25);
      rst             = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
